// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// State encoding, requester count and grant helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin search: first set request
// bit at or after ptr, wrapping modulo four.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    logic [SEL_W-1:0] k;

    // Scan farthest-first so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            k = ptr + SEL_W'(j);
            if (req[k]) begin
                found = 1'b1;
                index = k;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux with
// a tenure limit and registered grant/select/data.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W   = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  din_a,
    input  logic [DATA_W-1:0]  din_b,
    input  logic [DATA_W-1:0]  din_c,
    input  logic [DATA_W-1:0]  din_d,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy
);

    localparam logic [7:0] HOLD = 8'(MAX_HOLD);

    state_e             state;
    logic [SEL_W-1:0]   ptr;
    logic [7:0]         tenure;

    logic               idle_found;
    logic [SEL_W-1:0]   idle_idx;
    logic               next_found;
    logic [SEL_W-1:0]   next_idx;
    logic [NUM_REQ-1:0] others;
    logic [SEL_W-1:0]   after_owner;
    logic [DATA_W-1:0]  din_sel;

    // Requests other than the owner, searched starting just past it.
    assign others      = req & ~onehot(sel);
    assign after_owner = sel + 2'd1;

    rr_pick4 u_idle_pick (
        .req   (req),
        .ptr   (ptr),
        .found (idle_found),
        .index (idle_idx)
    );

    rr_pick4 u_next_pick (
        .req   (others),
        .ptr   (after_owner),
        .found (next_found),
        .index (next_idx)
    );

    // Data mux driven by the current owner index.
    always_comb begin
        din_sel = din_a;
        unique case (sel)
            2'd0: din_sel = din_a;
            2'd1: din_sel = din_b;
            2'd2: din_sel = din_c;
            2'd3: din_sel = din_d;
            default: din_sel = din_a;
        endcase
    end

    // Arbitration state machine with registered grant and data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            sel        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            ptr        <= '0;
            tenure     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (idle_found) begin
                        grant  <= onehot(idle_idx);
                        sel    <= idle_idx;
                        ptr    <= idle_idx + 2'd1;
                        tenure <= 8'd1;
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    dout       <= din_sel;
                    dout_valid <= 1'b1;
                    if (!req[sel] || tenure == HOLD) begin
                        if (next_found) begin
                            grant  <= onehot(next_idx);
                            sel    <= next_idx;
                            ptr    <= next_idx + 2'd1;
                            tenure <= 8'd1;
                        end else if (!req[sel]) begin
                            grant  <= '0;
                            busy   <= 1'b0;
                            tenure <= '0;
                            state  <= IDLE;
                        end else begin
                            tenure <= 8'd1;
                        end
                    end else begin
                        tenure <= tenure + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
